rom_port_arbiter: RTL and testbench

ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

---
 rtl/rom_arb_pkg.sv | 16 +
 rtl/rom_arb_prio.sv | 57 +++++
 rtl/rom_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_rom_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the ROM port arbiter.
package rom_arb_pkg;

  localparam int ROM_ADDR_W = 24;
  localparam int ROM_DATA_W = 16;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/rom_arb_prio.sv
// Winner pick for the ROM arbiter; with ROM_ARB_STARVE_EN defined it also keeps
// the count of consecutive p0 grants made while p1 was waiting.
module rom_arb_prio
  import rom_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic mclk,
  input  logic rst_n,
  input  logic p0_req,
  input  logic p1_req,
  input  logic arb_en,
  output logic win
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_cfg
    $error("rom_arb_prio: STARVE_LIMIT must be in 1..15");
  end

`ifdef ROM_ARB_STARVE_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;

  always_comb begin
    win      = P0;
    starve_d = starve_q;
    if (p1_req && (!p0_req || starve_q == LIMIT)) begin
      win = P1;
    end
    // The count only moves when a grant is actually being made.
    if (arb_en) begin
      if (win == P1 || !p1_req) begin
        starve_d = '0;
      end else begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_prio;
  assign unused_prio = ^{mclk, rst_n, arb_en, p1_req};

  always_comb begin
    win = p0_req ? P0 : P1;
  end
`endif

endmodule

// File: rtl/rom_port_arbiter.sv
// Two-port read arbiter sharing one ROM between the SNES mapper (p0) and a coprocessor (p1).
// Build option ROM_ARB_STARVE_EN enables the p1 starvation guard (see rom_arb_prio).
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ACCESS_CYCLES = 4,
  parameter int STARVE_LIMIT  = 3
) (
  input  logic        mclk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic [23:0] p0_addr,
  input  logic        p0_word,
  input  logic        p1_req,
  input  logic [23:0] p1_addr,
  input  logic        p1_word,
  output logic        p0_ack,
  output logic [15:0] p0_q,
  output logic        p1_ack,
  output logic [15:0] p1_q,
  output logic [23:0] rom_addr,
  output logic        rom_ce_n,
  output logic        rom_oe_n,
  output logic        rom_word,
  input  logic [15:0] rom_q,
  output logic        busy
);

  if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_cfg
    $error("rom_port_arbiter: ACCESS_CYCLES must be in 1..15");
  end

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    win_q, win_d;
  logic [ROM_ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                    rom_word_q, rom_word_d;
  logic                    strobe_n_q, strobe_n_d;
  logic                    p0_ack_q, p0_ack_d;
  logic                    p1_ack_q, p1_ack_d;
  logic [ROM_DATA_W-1:0]   p0_data_q, p0_data_d;
  logic [ROM_DATA_W-1:0]   p1_data_q, p1_data_d;
  logic                    busy_q, busy_d;

  logic arb_en;
  logic win_sel;

  assign arb_en = (state_q == ST_IDLE) && (p0_req || p1_req);

  rom_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .mclk   (mclk),
    .rst_n  (rst_n),
    .p0_req (p0_req),
    .p1_req (p1_req),
    .arb_en (arb_en),
    .win    (win_sel)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    win_d      = win_q;
    rom_addr_d = rom_addr_q;
    rom_word_d = rom_word_q;
    strobe_n_d = strobe_n_q;
    p0_ack_d   = 1'b0;
    p1_ack_d   = 1'b0;
    p0_data_d  = p0_data_q;
    p1_data_d  = p1_data_q;
    busy_d     = busy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_en) begin
          win_d      = win_sel;
          rom_addr_d = (win_sel == P1) ? p1_addr : p0_addr;
          rom_word_d = (win_sel == P1) ? p1_word : p0_word;
          strobe_n_d = 1'b0;
          cnt_d      = CNT_LOAD;
          busy_d     = 1'b1;
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Data and ack are registered together so q is valid in the ack cycle.
          if (win_q == P1) begin
            p1_data_d = rom_q;
            p1_ack_d  = 1'b1;
          end else begin
            p0_data_d = rom_q;
            p0_ack_d  = 1'b1;
          end
          strobe_n_d = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        strobe_n_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      win_q      <= P0;
      rom_addr_q <= '0;
      rom_word_q <= 1'b0;
      strobe_n_q <= 1'b1;
      p0_ack_q   <= 1'b0;
      p1_ack_q   <= 1'b0;
      p0_data_q  <= '0;
      p1_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      win_q      <= win_d;
      rom_addr_q <= rom_addr_d;
      rom_word_q <= rom_word_d;
      strobe_n_q <= strobe_n_d;
      p0_ack_q   <= p0_ack_d;
      p1_ack_q   <= p1_ack_d;
      p0_data_q  <= p0_data_d;
      p1_data_q  <= p1_data_d;
      busy_q     <= busy_d;
    end
  end

  assign p0_ack   = p0_ack_q;
  assign p1_ack   = p1_ack_q;
  assign p0_q     = p0_data_q;
  assign p1_q     = p1_data_q;
  assign rom_addr = rom_addr_q;
  assign rom_word = rom_word_q;
  assign rom_ce_n = strobe_n_q;
  assign rom_oe_n = strobe_n_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: transaction-level reference model plus directed pins.
module tb_rom_port_arbiter;

  localparam int AC = 4;
  localparam int SL = 3;

  logic        mclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req = 1'b0, p1_req = 1'b0;
  logic [23:0] p0_addr = '0, p1_addr = '0;
  logic        p0_word = 1'b0, p1_word = 1'b0;
  logic        p0_ack, p1_ack;
  logic [15:0] p0_q, p1_q;
  logic [23:0] rom_addr;
  logic        rom_ce_n, rom_oe_n, rom_word;
  logic [15:0] rom_q = '0;
  logic        busy;

  logic        b_p1_req = 1'b0;
  logic [23:0] b_p1_addr = '0;
  logic        b_p0_ack, b_p1_ack;
  logic [15:0] b_p0_q, b_p1_q;
  logic [23:0] b_rom_addr;
  logic        b_rom_ce_n, b_rom_oe_n, b_rom_word, b_busy;

  int checks = 0;
  int failures = 0;

  always #5 mclk = ~mclk;

  rom_port_arbiter #(.ACCESS_CYCLES(AC), .STARVE_LIMIT(SL)) dut (
    .mclk(mclk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_word(p0_word),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_word(p1_word),
    .p0_ack(p0_ack), .p0_q(p0_q), .p1_ack(p1_ack), .p1_q(p1_q),
    .rom_addr(rom_addr), .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n),
    .rom_word(rom_word), .rom_q(rom_q), .busy(busy)
  );

  rom_port_arbiter #(.ACCESS_CYCLES(1), .STARVE_LIMIT(SL)) dut_b (
    .mclk(mclk), .rst_n(rst_n),
    .p0_req(1'b0), .p0_addr(24'h0), .p0_word(1'b0),
    .p1_req(b_p1_req), .p1_addr(b_p1_addr), .p1_word(1'b1),
    .p0_ack(b_p0_ack), .p0_q(b_p0_q), .p1_ack(b_p1_ack), .p1_q(b_p1_q),
    .rom_addr(b_rom_addr), .rom_ce_n(b_rom_ce_n), .rom_oe_n(b_rom_oe_n),
    .rom_word(b_rom_word), .rom_q(16'hA5C3), .busy(b_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ROM contents; rom_fix pins a known word for the directed read.
  logic        rom_fix = 1'b0;
  logic [15:0] rom_fix_val = '0;

  function automatic logic [15:0] rom_f(input logic [23:0] a, input logic w);
    if (rom_fix) return rom_fix_val;
    return a[15:0] ^ {a[23:16], a[7:0]} ^ (w ? 16'h3C3C : 16'h00C3);
  endfunction

  // ROM device: data only becomes valid after AC cycles of CE/OE low; garbage otherwise.
  int low_cnt = 0;
  always @(negedge mclk) begin
    if (!rom_ce_n && !rom_oe_n) low_cnt++;
    else low_cnt = 0;
    rom_q = (low_cnt == AC) ? rom_f(rom_addr, rom_word) : 16'($urandom);
  end

  // Reference model: one access in flight, identified by its age in cycles since grant.
  bit          m_active = 0;
  int          m_age = 0;
  int          m_win = 0;
  int          m_starve = 0;
  logic [23:0] m_addr = '0;
  logic        m_word = 1'b0;
  logic [15:0] m_q [2] = '{16'h0, 16'h0};

  always @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_age = 0; m_starve = 0;
      m_addr = '0; m_word = 1'b0;
      m_q[0] = '0; m_q[1] = '0;
    end else begin
      if (m_active) begin
        m_age++;
        if (m_age > AC + 1) m_active = 0;
      end else if (p0_req || p1_req) begin
`ifdef ROM_ARB_STARVE_EN
        if (p1_req && (!p0_req || m_starve == SL)) begin
          m_win = 1; m_starve = 0;
        end else begin
          m_win = 0; m_starve = p1_req ? m_starve + 1 : 0;
        end
`else
        m_win = p0_req ? 0 : 1;
`endif
        m_active = 1;
        m_age = 1;
        m_addr = m_win ? p1_addr : p0_addr;
        m_word = m_win ? p1_word : p0_word;
      end
      if (m_active && m_age == AC + 1) m_q[m_win] = rom_f(m_addr, m_word);
    end
  end

  bit cmp_en = 0;
  always @(negedge mclk) begin
    if (cmp_en) begin
      logic e_strb_n, e_done;
      e_strb_n = !(m_active && m_age <= AC);
      e_done   = m_active && (m_age == AC + 1);
      chk("m_busy", busy, m_active);
      chk("m_ce_n", rom_ce_n, e_strb_n);
      chk("m_oe_n", rom_oe_n, e_strb_n);
      chk("m_addr", rom_addr, m_addr);
      chk("m_word", rom_word, m_word);
      chk("m_ack0", p0_ack, e_done && m_win == 0);
      chk("m_ack1", p1_ack, e_done && m_win == 1);
      chk("m_q0", p0_q, m_q[0]);
      chk("m_q1", p1_q, m_q[1]);
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge mclk);
    while (busy && n < 50) begin
      @(negedge mclk);
      n++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  initial begin
    int ack0, ack1, low, busy_n, saw;
    int ord [$];

    repeat (2) @(negedge mclk);
    chk("rst_ce_n", rom_ce_n, 1'b1);
    chk("rst_oe_n", rom_oe_n, 1'b1);
    chk("rst_addr", rom_addr, 24'h0);
    chk("rst_word", rom_word, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_acks", {p0_ack, p1_ack}, 2'b00);
    chk("rst_q", {p0_q, p1_q}, 32'h0);
    #2 rst_n = 1'b1;
    cmp_en = 1;

    // Single p0 word read of a fixed ROM word.
    wait_idle();
    rom_fix = 1'b1; rom_fix_val = 16'hBEEF;
    p0_req = 1'b1; p0_addr = 24'h123456; p0_word = 1'b1;
    low = 0; ack0 = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge mclk);
      if (!rom_ce_n && !rom_oe_n) low++;
      if (p0_ack && ack0 < 0) begin
        ack0 = k;
        chk("t1_q", p0_q, 16'hBEEF);
        chk("t1_addr", rom_addr, 24'h123456);
        chk("t1_word", rom_word, 1'b1);
        p0_req = 1'b0;
      end
    end
    chk("t1_low_cycles", low, 4);
    chk("t1_ack_cycle", ack0, 5);
    rom_fix = 1'b0;

    // Simultaneous requests.
    wait_idle();
    p0_req = 1'b1; p0_addr = 24'h000100; p0_word = 1'b0;
    p1_req = 1'b1; p1_addr = 24'h200200; p1_word = 1'b1;
`ifdef ROM_ARB_STARVE_EN
    ord.delete();
    ack0 = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge mclk);
      if (ord.size() < 8) begin
        if (p0_ack) ord.push_back(0);
        if (p1_ack) ord.push_back(1);
        if (ord.size() == 1 && ack0 < 0) ack0 = k;
        if (ord.size() == 8) begin p0_req = 1'b0; p1_req = 1'b0; end
      end
    end
    chk("t2_ack_count", ord.size(), 8);
    chk("t2_first_ack", ack0, 5);
    for (int i = 0; i < ord.size(); i++) chk("t2_order", ord[i], (i % 4 == 3) ? 1 : 0);
`else
    ack0 = -1; ack1 = -1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge mclk);
      if (p0_ack) begin if (ack0 < 0) ack0 = k; p0_req = 1'b0; end
      if (p1_ack) begin if (ack1 < 0) ack1 = k; p1_req = 1'b0; end
    end
    chk("t2_p0_ack", ack0, 5);
    chk("t2_p1_ack", ack1, 11);
    chk("t2_spacing", ack1 - ack0, 6);
`endif
    p0_req = 1'b0; p1_req = 1'b0;

    // p1 drops req and changes address during the access.
    wait_idle();
    p1_req = 1'b1; p1_addr = 24'h00A0B0; p1_word = 1'b0;
    ack1 = -1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge mclk);
      if (k == 2) begin p1_req = 1'b0; p1_addr = 24'hFFFFFF; p1_word = 1'b1; end
      chk("t3_addr_hold", rom_addr, 24'h00A0B0);
      if (p1_ack && ack1 < 0) ack1 = k;
    end
    chk("t3_ack_cycle", ack1, 5);
    chk("t3_word_hold", rom_word, 1'b0);

    // Reset in the third access cycle.
    wait_idle();
    p0_req = 1'b1; p0_addr = 24'h0F0F0F; p0_word = 1'b1;
    repeat (3) @(negedge mclk);
    chk("t4_pre_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_ce_n", rom_ce_n, 1'b1);
    chk("t4_oe_n", rom_oe_n, 1'b1);
    chk("t4_busy", busy, 1'b0);
    chk("t4_ack", {p0_ack, p1_ack}, 2'b00);
    p0_req = 1'b0;
    @(negedge mclk);
    #2 rst_n = 1'b1;
    saw = 0; busy_n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge mclk);
      if (p0_ack || p1_ack) saw++;
      if (busy) busy_n++;
    end
    chk("t4_no_ack", saw, 0);
    chk("t4_stay_idle", busy_n, 0);

    // ACCESS_CYCLES = 1 instance, single p1 read.
    b_p1_req = 1'b1; b_p1_addr = 24'hABCDEF;
    busy_n = 0; ack1 = -1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge mclk);
      if (b_busy) busy_n++;
      if (b_p1_ack && ack1 < 0) begin
        ack1 = k;
        chk("t5_q", b_p1_q, 16'hA5C3);
        b_p1_req = 1'b0;
      end
    end
    chk("t5_ack_cycle", ack1, 2);
    chk("t5_busy_cycles", busy_n, 2);
    chk("t5_addr", b_rom_addr, 24'hABCDEF);
    chk("t5_word", b_rom_word, 1'b1);
    chk("t5_strobes", {b_rom_ce_n, b_rom_oe_n}, 2'b11);
    chk("t5_p0_idle", {b_p0_ack, b_p0_q}, 17'h0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge mclk);
      if (p0_req && p0_ack && $urandom_range(3) != 0) p0_req = 1'b0;
      else if (!p0_req && $urandom_range(3) == 0) p0_req = 1'b1;
      else if (p0_req && $urandom_range(15) == 0) p0_req = 1'b0;
      if (p1_req && p1_ack && $urandom_range(3) != 0) p1_req = 1'b0;
      else if (!p1_req && $urandom_range(3) == 0) p1_req = 1'b1;
      else if (p1_req && $urandom_range(15) == 0) p1_req = 1'b0;
      if ($urandom_range(3) == 0) begin p0_addr = 24'($urandom); p0_word = 1'($urandom); end
      if ($urandom_range(3) == 0) begin p1_addr = 24'($urandom); p1_word = 1'($urandom); end
      if ($urandom_range(499) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge mclk);
        #2 rst_n = 1'b1;
      end
    end

    p0_req = 1'b0; p1_req = 1'b0;
    repeat (10) @(negedge mclk);
    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
